// File: rtl/uart_pkg.sv
// Shared types and default framing constants for the UART command parser.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         DEFAULT_MAX_LEN   = 16;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: counts enabled cycles, saturates at LIMIT and flags expiry.
// Latency: expired is combinational from the count register; clr wins over en.
// Backpressure: none; the parent decides when counting is meaningful through en.
module uart_cmd_timer #(
    parameter int LIMIT = 24000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC,LEN,payload,CSUM frames from an RX FIFO and streams the payload out.
// Latency: each byte takes a fetch and a sample cycle; outputs are registered.
// Backpressure: FIFO reads stall while m_valid_o is held; optional timeout via UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = DATA_WIDTH'(DEFAULT_SYNC_BYTE),
    parameter int                    MAX_LEN        = DEFAULT_MAX_LEN,
    parameter int                    TIMEOUT_CYCLES = 24000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    output logic                  read_en_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  frame_ok_o,
    output logic                  frame_err_o,
    output logic                  busy_o
);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] csum, csum_nxt;
    logic                  smp;
    logic                  rd_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  valid_nxt, last_nxt;
    logic                  ok_nxt, err_nxt;
    logic                  tmo_expired;

`ifdef UART_CMD_TIMEOUT_EN
    // Only idle-input time counts; a held payload byte is downstream's stall, not ours.
    uart_cmd_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (smp || (state == ST_HUNT)),
        .en      (fifo_empty_i && !m_valid_o),
        .expired (tmo_expired)
    );
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign tmo_expired           = 1'b0;
`endif

    assign busy_o = (state != ST_HUNT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        csum_nxt  = csum;
        data_nxt  = m_data_o;
        valid_nxt = m_valid_o;
        last_nxt  = m_last_o;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        // One byte in flight at most; never fetch while a payload byte is pending.
        rd_nxt    = !fifo_empty_i && !read_en_o && !smp && !m_valid_o;

        if (m_valid_o && m_ready_i) begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
        end

        if (smp) begin
            unique case (state)
                ST_HUNT: begin
                    if (fifo_dout_i == SYNC_BYTE) begin
                        state_nxt = ST_LEN;
                    end
                end
                ST_LEN: begin
                    csum_nxt = fifo_dout_i;
                    cnt_nxt  = fifo_dout_i;
                    if (fifo_dout_i > DATA_WIDTH'(MAX_LEN)) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_HUNT;
                    end else if (fifo_dout_i == '0) begin
                        state_nxt = ST_CSUM;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    data_nxt  = fifo_dout_i;
                    valid_nxt = 1'b1;
                    csum_nxt  = csum ^ fifo_dout_i;
                    cnt_nxt   = cnt - 1'b1;
                    last_nxt  = (cnt == DATA_WIDTH'(1));
                    // The pending last byte already blocks the checksum fetch until it transfers.
                    if (cnt == DATA_WIDTH'(1)) begin
                        state_nxt = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (fifo_dout_i == csum) begin
                        ok_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = ST_HUNT;
                end
                default: state_nxt = ST_HUNT;
            endcase
        end else if (tmo_expired && (state != ST_HUNT)) begin
            err_nxt   = 1'b1;
            state_nxt = ST_HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_HUNT;
            cnt         <= '0;
            csum        <= '0;
            smp         <= 1'b0;
            read_en_o   <= 1'b0;
            m_data_o    <= '0;
            m_valid_o   <= 1'b0;
            m_last_o    <= 1'b0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            csum        <= csum_nxt;
            smp         <= read_en_o;
            read_en_o   <= rd_nxt;
            m_data_o    <= data_nxt;
            m_valid_o   <= valid_nxt;
            m_last_o    <= last_nxt;
            frame_ok_o  <= ok_nxt;
            frame_err_o <= err_nxt;
        end
    end

endmodule
